// File: rtl/cond_logic_if.sv
// Decode-to-condition-unit bundle: instruction qualifiers in, gated enables,
// architectural flags and performance counters out.
interface cond_logic_if;
    logic        Valid;
    logic [3:0]  Cond;
    logic [3:0]  ALUFlags;
    logic [1:0]  FlagW;
    logic        PCS;
    logic        RegW;
    logic        MemW;
    logic        NoWrite;
    logic        PCSrc;
    logic        RegWrite;
    logic        MemWrite;
    logic        CondEx;
    logic [3:0]  Flags;
    logic [15:0] ExecCount;
    logic [15:0] SquashCount;

    modport master (
        output Valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags, ExecCount, SquashCount
    );

    modport slave (
        input  Valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags, ExecCount, SquashCount
    );
endinterface

// File: rtl/cond_logic.sv
// ARM condition check: evaluates Cond against the registered NZCV flags,
// gates write enables, updates flags and counts executed/squashed instructions.
module cond_logic (
    input  logic        clk,
    input  logic        reset,
    cond_logic_if.slave bus
);

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE, CS, CC, MI, PL, VS, VC,
        HI, LS, GE, LT, GT, LE, AL, NV
    } cond_e;

    logic [3:0]  flags;
    logic [15:0] exec_count;
    logic [15:0] squash_count;
    logic        n, z, c, v;
    logic        cond_pass;
    logic        cond_ex;

    assign {n, z, c, v} = flags;

    // Only the registered flags feed the check; same-cycle ALUFlags never do.
    always_comb begin
        // NOTE: default assigned first so every path drives cond_pass and no latch is inferred.
        cond_pass = 1'b0;
        case (cond_e'(bus.Cond))
            EQ: cond_pass = z;
            NE: cond_pass = ~z;
            CS: cond_pass = c;
            CC: cond_pass = ~c;
            MI: cond_pass = n;
            PL: cond_pass = ~n;
            VS: cond_pass = v;
            VC: cond_pass = ~v;
            HI: cond_pass = c & ~z;
            LS: cond_pass = ~c | z;
            GE: cond_pass = (n == v);
            LT: cond_pass = (n != v);
            GT: cond_pass = ~z & (n == v);
            LE: cond_pass = z | (n != v);
            AL: cond_pass = 1'b1;
            NV: cond_pass = 1'b0;
        endcase
    end

    // Folding reset in here forces every enable low while reset is held.
    assign cond_ex = bus.Valid & cond_pass & reset;

    assign bus.CondEx   = cond_ex;
    assign bus.PCSrc    = bus.PCS & cond_ex;
    assign bus.RegWrite = bus.RegW & cond_ex & ~bus.NoWrite;
    assign bus.MemWrite = bus.MemW & cond_ex;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            flags        <= 4'b0000;
            exec_count   <= 16'h0000;
            squash_count <= 16'h0000;
        end else begin
            if (cond_ex && bus.FlagW[1]) flags[3:2] <= bus.ALUFlags[3:2];
            if (cond_ex && bus.FlagW[0]) flags[1:0] <= bus.ALUFlags[1:0];

            // Counters stick at all-ones instead of wrapping.
            if (bus.Valid && cond_ex && exec_count != 16'hFFFF)
                exec_count <= exec_count + 16'd1;
            if (bus.Valid && !cond_ex && squash_count != 16'hFFFF)
                squash_count <= squash_count + 16'd1;
        end
    end

    assign bus.Flags       = flags;
    assign bus.ExecCount   = exec_count;
    assign bus.SquashCount = squash_count;

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named exactly as the codebase does; polarity and synchronicity are fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 Valid  input  1  the current instruction is real; 0 means a bubble.
REQ-005 Cond  input  4  ARM condition field, Instr[31:28].
REQ-006 ALUFlags  input  4  {Negative, Zero, Carry, Overflow}, taken directly from the ALU flag outputs.
REQ-007 FlagW  input  2  flag-write request: bit1 covers N and Z; bit0 covers C and V.
REQ-008 PCS, RegW, MemW, NoWrite  input  1 each  decoder requests; NoWrite is set for CMP/CMN/TST/TEQ.
REQ-009 PCSrc, RegWrite, MemWrite  output  1 each  gated, condition-qualified write enables.
REQ-010 CondEx  output  1  the condition passed for a valid instruction.
REQ-011 Flags  output  4  registered {N, Z, C, V}.
REQ-012 ExecCount, SquashCount  output  16 each  performance counters.

Function
REQ-013 Condition evaluation SHALL use only the registered Flags, never ALUFlags of the same cycle, as follows:
- 0000 EQ Z; 0001 NE ~Z
- 0010 CS C; 0011 CC ~C
- 0100 MI N; 0101 PL ~N
- 0110 VS V; 0111 VC ~V
- 1000 HI C&~Z; 1001 LS ~C|Z
- 1010 GE N==V; 1011 LT N!=V
- 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
- 1110 AL 1; 1111 reserved, evaluates to 0
REQ-014 CondEx SHALL equal Valid & condition-pass & reset, combinationally, with zero latency.
REQ-015 PCSrc SHALL equal PCS & CondEx.
REQ-016 RegWrite SHALL equal RegW & CondEx & ~NoWrite.
REQ-017 MemWrite SHALL equal MemW & CondEx.
REQ-018 At the rising edge, if CondEx & FlagW[1], Flags[3:2] SHALL load ALUFlags[3:2]; otherwise they hold.
REQ-019 At the rising edge, if CondEx & FlagW[0], Flags[1:0] SHALL load ALUFlags[1:0]; otherwise they hold.
REQ-020 New flag values SHALL be visible to the condition of the next cycle's instruction, a 1-cycle latency; a failed condition SHALL NOT update any flag.
REQ-021 When NoWrite=1, the flag update SHALL still occur per FlagW, while RegWrite is suppressed.
REQ-022 ExecCount SHALL increment by 1 on each edge where Valid & CondEx.
REQ-023 SquashCount SHALL increment by 1 on each edge where Valid & ~CondEx.
REQ-024 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-025 When Valid=0, all gated outputs SHALL be 0, no flag SHALL update, and no counter SHALL change.
REQ-026 The block SHALL contain no state machine beyond the flag and counter registers; it is a single stage with no stall input.

Reset
REQ-027 With reset=0 at a rising edge, Flags SHALL become 4'b0000 and ExecCount and SquashCount SHALL become 0.
REQ-028 While reset=0, CondEx, PCSrc, RegWrite and MemWrite SHALL be forced to 0 combinationally, regardless of the other inputs.
REQ-029 If reset is asserted mid-stream, any flag update or count requested in that same cycle SHALL be discarded; reset has priority.
REQ-030 On the first cycle after reset release, conditions SHALL evaluate against Flags=0000: EQ fails, NE passes, GE passes.

Verification
REQ-031 Bench scenario, reset: hold reset=0 for 2 cycles with Valid=1, Cond=1110, RegW=1 -> RegWrite=0 throughout; after the edge, Flags=0000 and both counters are 0.
REQ-032 Bench scenario, flag latency: cycle 0 Cond=1110, FlagW=11, ALUFlags=0100 (Z); cycle 1 Cond=0000, RegW=1 -> cycle 0 RegWrite=0 (NoWrite=1, CMP); cycle 1 CondEx=1, RegWrite=1; ExecCount=2.
REQ-033 Bench scenario, squash: with Flags=0000, Cond=0000, PCS=1, MemW=1, FlagW=11, ALUFlags=1111 -> PCSrc=0, MemWrite=0, Flags remain 0000, SquashCount increments by 1.
REQ-034 Bench scenario, signed compare: after a SUB of 80000000 - 7FFFFFFF with ALUFlags=0011 (C, V) and FlagW=11 -> Flags=0011; GE fails, LT passes, HI passes, GT fails.
REQ-035 Bench scenario, partial write: with Flags=1000, FlagW=01, ALUFlags=0110 -> Flags=1010 (N held, Z not loaded, C loaded, V loaded).
REQ-036 Bench scenario, saturation and bubble: force 65,537 valid AL instructions -> ExecCount=FFFF (no wrap); then Valid=0 for 3 cycles -> counters and Flags unchanged and all enables 0.
